// File: rtl/sr_drive_ctrl_if.sv
// Request/feedback/status bundle between a requester, the SR flip-flop and sr_drive_ctrl.
// Combinational bundle; no latency, no backpressure (level requests, pulse status).
interface sr_drive_ctrl_if;
    logic set_req;
    logic clr_req;
    logic q_fb;
    logic s;
    logic r;
    logic busy;
    logic done;
    logic err;
    logic target;

    modport master (
        output set_req,
        output clr_req,
        output q_fb,
        input  s,
        input  r,
        input  busy,
        input  done,
        input  err,
        input  target
    );

    modport slave (
        input  set_req,
        input  clr_req,
        input  q_fb,
        output s,
        output r,
        output busy,
        output done,
        output err,
        output target
    );
endinterface

// File: rtl/sr_drive_ctrl.sv
// Pulses S or R of a downstream SR flip-flop for HOLD_CYC cycles, then waits up to TIMEOUT cycles for Q_FB.
// All outputs registered (1-cycle); requests ignored while busy, so a held request acts as retry.
module sr_drive_ctrl #(
    parameter int unsigned HOLD_CYC = 2,
    parameter int unsigned TIMEOUT  = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    sr_drive_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LD = 4'(HOLD_CYC);
    localparam logic [3:0] TMO_LD  = 4'(TIMEOUT);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       s_q, s_d;
    logic       r_q, r_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       target_q, target_d;
    logic       q_meta_q;
    logic       q_sync_q;

    // Q_FB is produced by logic outside this clock domain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_meta_q <= 1'b0;
            q_sync_q <= 1'b0;
        end else begin
            q_meta_q <= bus.q_fb;
            q_sync_q <= q_meta_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            s_q      <= 1'b0;
            r_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            target_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            s_q      <= s_d;
            r_q      <= r_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        s_d      = s_q;
        r_d      = r_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        target_d = target_q;

        case (state_q)
            IDLE: begin
                s_d = 1'b0;
                r_d = 1'b0;
                if (bus.set_req && bus.clr_req) begin
                    err_d = 1'b1;
                end else if (bus.set_req) begin
                    state_d  = DRIVE;
                    target_d = 1'b1;
                    s_d      = 1'b1;
                    cnt_d    = HOLD_LD;
                end else if (bus.clr_req) begin
                    state_d  = DRIVE;
                    target_d = 1'b0;
                    r_d      = 1'b1;
                    cnt_d    = HOLD_LD;
                end
            end

            DRIVE: begin
                // cnt_q counts the cycles the command has left, including the current one.
                if (cnt_q <= 4'd1) begin
                    state_d = SETTLE;
                    s_d     = 1'b0;
                    r_d     = 1'b0;
                    cnt_d   = TMO_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            SETTLE: begin
                s_d = 1'b0;
                r_d = 1'b0;
                if (q_sync_q == target_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    cnt_d   = 4'd0;
                end else if (cnt_q <= 4'd1) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            default: begin
                state_d = IDLE;
                s_d     = 1'b0;
                r_d     = 1'b0;
                cnt_d   = 4'd0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.s      = s_q;
    assign bus.r      = r_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.target = target_q;

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Bench for sr_drive_ctrl: timeline reference model, per-cycle compare, directed and random stimulus.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_sr_drive_ctrl;

    localparam int H    = 2;
    localparam int T    = 8;
    localparam int NHIS = 8192;

    logic clk;
    logic rst;
    logic q_ff;
    logic q_rnd;
    int   qmode;  // 0: flip-flop model, 1: tied 0, 2: tied 1, 3: random

    sr_drive_ctrl_if bus ();

    sr_drive_ctrl #(.HOLD_CYC(H), .TIMEOUT(T)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.q_fb = (qmode == 0) ? q_ff :
                      (qmode == 1) ? 1'b0 :
                      (qmode == 2) ? 1'b1 : q_rnd;

    // Downstream SR flip-flop: follows S/R on the falling edge.
    initial begin
        q_ff  = 1'b0;
        q_rnd = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.s)      q_ff = 1'b1;
            else if (bus.r) q_ff = 1'b0;
            q_rnd = 1'($urandom_range(0, 1));
        end
    end

    int n_vec;
    int n_bad;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Running totals of DUT outputs, sampled where the compare process samples.
    int s_cnt, r_cnt, busy_cnt, done_cnt, err_cnt;

    // Reference model: a command accepted at edge n0 drives for edges n0..n0+H-1,
    // then confirmation is checked at edges n0+H+1..n0+H+T against Q_FB as it was two edges earlier.
    logic qhist [NHIS];
    initial begin
        int  m;
        int  n0;
        bit  mbusy, mtgt, done_e, err_e, s_e, r_e;
        bit  sv, cv, qv, rv;
        int  act, exp;
        m = 0; n0 = 0; mbusy = 0; mtgt = 0;
        s_cnt = 0; r_cnt = 0; busy_cnt = 0; done_cnt = 0; err_cnt = 0;
        forever begin
            @(posedge clk);
            sv = bus.set_req; cv = bus.clr_req; qv = bus.q_fb; rv = rst;
            done_e = 0; err_e = 0;
            if (m >= NHIS) begin
                check("history_overflow", m, NHIS - 1);
                $fatal(1, "history exhausted");
            end
            if (rv) begin
                mbusy = 0; mtgt = 0;
                qhist[m] = 1'b0;
                if (m > 0) qhist[m-1] = 1'b0;
            end else begin
                qhist[m] = qv;
                if (mbusy) begin
                    if (m > n0 + H && m >= 2) begin
                        if (qhist[m-2] == mtgt) begin
                            done_e = 1; mbusy = 0;
                        end else if (m == n0 + H + T) begin
                            err_e = 1; mbusy = 0;
                        end
                    end
                end else if (sv && cv) begin
                    err_e = 1;
                end else if (sv || cv) begin
                    mbusy = 1; n0 = m; mtgt = sv;
                end
            end
            s_e = mbusy &&  mtgt && (m < n0 + H);
            r_e = mbusy && !mtgt && (m < n0 + H);
            #1;
            exp = {26'd0, s_e, r_e, mbusy, done_e, err_e, mtgt};
            act = {26'd0, bus.s, bus.r, bus.busy, bus.done, bus.err, bus.target};
            check("cycle{s,r,busy,done,err,target}", act, exp);
            s_cnt    += int'(bus.s);
            r_cnt    += int'(bus.r);
            busy_cnt += int'(bus.busy);
            done_cnt += int'(bus.done);
            err_cnt  += int'(bus.err);
            m++;
        end
    end

    int b_s, b_r, b_busy, b_done, b_err;

    task automatic snap();
        b_s = s_cnt; b_r = r_cnt; b_busy = busy_cnt; b_done = done_cnt; b_err = err_cnt;
    endtask

    task automatic pulse_req(input bit set_v, input bit clr_v);
        @(negedge clk);
        bus.set_req = set_v;
        bus.clr_req = clr_v;
        @(negedge clk);
        bus.set_req = 1'b0;
        bus.clr_req = 1'b0;
    endtask

    task automatic expect_counts(input string tag, input int es, input int er,
                                 input int ebusy, input int edone, input int eerr);
        check({tag, "_s_cycles"},    s_cnt - b_s,       es);
        check({tag, "_r_cycles"},    r_cnt - b_r,       er);
        check({tag, "_busy_cycles"}, busy_cnt - b_busy, ebusy);
        check({tag, "_done_pulses"}, done_cnt - b_done, edone);
        check({tag, "_err_pulses"},  err_cnt - b_err,   eerr);
    endtask

    initial begin
        int rv;
        n_vec = 0; n_bad = 0;
        rst = 1'b1;
        qmode = 0;
        bus.set_req = 1'b0;
        bus.clr_req = 1'b0;
        #1;
        check("reset_outputs", {bus.s, bus.r, bus.busy, bus.done, bus.err, bus.target}, 0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        repeat (2) @(negedge clk);

        // Set with flip-flop present: S for 2 cycles, DONE once Q_FB has crossed the synchronizer.
        snap();
        pulse_req(1'b1, 1'b0);
        repeat (14) @(negedge clk);
        expect_counts("set", 2, 0, 3, 1, 0);
        check("set_target", int'(bus.target), 1);

        snap();
        pulse_req(1'b0, 1'b1);
        repeat (14) @(negedge clk);
        expect_counts("clr", 0, 2, 3, 1, 0);
        check("clr_target", int'(bus.target), 0);

        snap();
        pulse_req(1'b1, 1'b1);
        repeat (6) @(negedge clk);
        expect_counts("conflict", 0, 0, 0, 0, 1);
        check("conflict_target", int'(bus.target), 0);

        // Q_FB stuck low: ERR lands T cycles after S falls.
        qmode = 1;
        snap();
        pulse_req(1'b1, 1'b0);
        repeat (16) @(negedge clk);
        expect_counts("timeout", 2, 0, H + T, 0, 1);
        qmode = 0;
        pulse_req(1'b0, 1'b1);
        repeat (14) @(negedge clk);

        // Clear requests arriving mid-command are not acted on.
        snap();
        @(negedge clk);
        bus.set_req = 1'b1;
        @(negedge clk);
        bus.set_req = 1'b0;
        bus.clr_req = 1'b1;
        @(negedge clk);
        bus.clr_req = 1'b0;
        @(negedge clk);
        bus.clr_req = 1'b1;
        @(negedge clk);
        bus.clr_req = 1'b0;
        repeat (12) @(negedge clk);
        expect_counts("ignore_clr", 2, 0, 3, 1, 0);
        check("ignore_clr_target", int'(bus.target), 1);

        // Reset mid-drive drops S without a clock edge.
        pulse_req(1'b0, 1'b1);
        repeat (14) @(negedge clk);
        snap();
        @(negedge clk);
        bus.set_req = 1'b1;
        @(negedge clk);
        bus.set_req = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_outputs", {bus.s, bus.r, bus.busy, bus.done, bus.err, bus.target}, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_no_done", done_cnt - b_done, 0);
        check("rst_no_err", err_cnt - b_err, 0);
        snap();
        pulse_req(1'b1, 1'b0);
        repeat (14) @(negedge clk);
        expect_counts("after_rst", 2, 0, 3, 1, 0);

        // Randomized traffic, feedback modes and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rv = int'($urandom_range(0, 999));
            if (rv < 5) begin
                @(posedge clk);
                #3 rst = 1'b1;
                repeat (int'($urandom_range(1, 3))) @(posedge clk);
                #3 rst = 1'b0;
                @(negedge clk);
            end
            if (rv >= 5 && rv < 35) qmode = int'($urandom_range(0, 6)) % 4;
            rv = int'($urandom_range(0, 99));
            bus.set_req = (rv < 20);
            bus.clr_req = (rv >= 15 && rv < 35);
        end
        bus.set_req = 1'b0;
        bus.clr_req = 1'b0;
        qmode = 0;
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
